// File: rtl/fwd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : fwd_pkg                                                       |
// | Description : Source codes, code-width helper and history entry layout for  |
// |               the operand forwarding selector.                              |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package fwd_pkg;

    localparam int SRC_RF         = 0;
    localparam int SRC_STAGE_BASE = 1;

    localparam int FWD_ADDR_W = 5;
    localparam int FWD_DATA_W = 32;

    // Layout of one retired-write record at the default widths; the history
    // buffer declares the same layout sized by its own parameters.
    typedef struct packed {
        logic                  valid;
        logic [FWD_ADDR_W-1:0] addr;
        logic [FWD_DATA_W-1:0] data;
    } fwd_entry_t;

    function automatic int src_retire(input int num_stages);
        return num_stages + 1;
    endfunction

    function automatic int src_hist(input int num_stages, input int j);
        return num_stages + 2 + j;
    endfunction

    function automatic int src_width(input int num_stages, input int hist_depth);
        return $clog2(num_stages + hist_depth + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/forward_hist_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : forward_hist_buf                                              |
// | Description : Shift register of recently retired register writes, newest   |
// |               in entry 0; writes to register 0 are never recorded.          |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module forward_hist_buf
    import fwd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int HIST_DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             retire_wen_i,
    input  logic [REG_ADDR_W-1:0]            retire_addr_i,
    input  logic [DATA_WIDTH-1:0]            retire_data_i,
    output logic [HIST_DEPTH-1:0]            hist_valid_o,
    output logic [HIST_DEPTH*REG_ADDR_W-1:0] hist_addr_o,
    output logic [HIST_DEPTH*DATA_WIDTH-1:0] hist_data_o
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } hist_entry_t;

    hist_entry_t [HIST_DEPTH-1:0] hist_q;
    logic                         push;

    assign push = retire_wen_i && (retire_addr_i != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else if (push) begin
            hist_q[0] <= '{valid: 1'b1, addr: retire_addr_i, data: retire_data_i};
            for (int j = 1; j < HIST_DEPTH; j++) begin
                hist_q[j] <= hist_q[j-1];
            end
        end
    end

    generate
        for (genvar j = 0; j < HIST_DEPTH; j++) begin : g_flat
            assign hist_valid_o[j]                           = hist_q[j].valid;
            assign hist_addr_o[j*REG_ADDR_W +: REG_ADDR_W]   = hist_q[j].addr;
            assign hist_data_o[j*DATA_WIDTH +: DATA_WIDTH]   = hist_q[j].data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/forward_select_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : forward_select_unit                                           |
// | Description : Per-operand forwarding mux: producers, retire port, retired-  |
// |               write history or register file, with load-use stall.          |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module forward_select_unit
    import fwd_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int REG_ADDR_W = 5,
    parameter  int NUM_STAGES = 2,
    parameter  int HIST_DEPTH = 2,
    localparam int SRC_W      = src_width(NUM_STAGES, HIST_DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [REG_ADDR_W-1:0]            in_addr,
    input  logic [DATA_WIDTH-1:0]            in_rf_data,
    input  logic [NUM_STAGES-1:0]            stage_wen,
    input  logic [NUM_STAGES*REG_ADDR_W-1:0] stage_addr,
    input  logic [NUM_STAGES*DATA_WIDTH-1:0] stage_data,
    input  logic [NUM_STAGES-1:0]            stage_data_ok,
    input  logic                             retire_wen,
    input  logic [REG_ADDR_W-1:0]            retire_addr,
    input  logic [DATA_WIDTH-1:0]            retire_data,
    input  logic                             flush,
    output logic                             stall,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [SRC_W-1:0]                 out_src
);

    logic [HIST_DEPTH-1:0]            hist_valid;
    logic [HIST_DEPTH*REG_ADDR_W-1:0] hist_addr;
    logic [HIST_DEPTH*DATA_WIDTH-1:0] hist_data;

    logic                  sel_hit;
    logic                  sel_pending;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [SRC_W-1:0]      sel_src;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [SRC_W-1:0]      out_src_q,   out_src_d;

    forward_hist_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk           (clk),
        .rst_n         (rst_n),
        .retire_wen_i  (retire_wen),
        .retire_addr_i (retire_addr),
        .retire_data_i (retire_data),
        .hist_valid_o  (hist_valid),
        .hist_addr_o   (hist_addr),
        .hist_data_o   (hist_data)
    );

    // First hit wins; history is the pre-shift view, so a live retire beats it.
    always_comb begin
        sel_hit     = 1'b0;
        sel_pending = 1'b0;
        sel_data    = '0;
        sel_src     = SRC_W'(SRC_RF);
        if (in_addr != '0) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (!sel_hit && stage_wen[i] &&
                    (stage_addr[i*REG_ADDR_W +: REG_ADDR_W] == in_addr)) begin
                    sel_hit     = 1'b1;
                    sel_pending = !stage_data_ok[i];
                    sel_data    = stage_data[i*DATA_WIDTH +: DATA_WIDTH];
                    sel_src     = SRC_W'(SRC_STAGE_BASE + i);
                end
            end
            if (!sel_hit && retire_wen && (retire_addr == in_addr)) begin
                sel_hit  = 1'b1;
                sel_data = retire_data;
                sel_src  = SRC_W'(src_retire(NUM_STAGES));
            end
            for (int j = 0; j < HIST_DEPTH; j++) begin
                if (!sel_hit && hist_valid[j] &&
                    (hist_addr[j*REG_ADDR_W +: REG_ADDR_W] == in_addr)) begin
                    sel_hit  = 1'b1;
                    sel_data = hist_data[j*DATA_WIDTH +: DATA_WIDTH];
                    sel_src  = SRC_W'(src_hist(NUM_STAGES, j));
                end
            end
            if (!sel_hit) begin
                sel_data = in_rf_data;
            end
        end
    end

    assign stall = in_valid && sel_pending;

    always_comb begin
        out_valid_d = in_valid && !stall && !flush;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (out_valid_d) begin
            out_data_d = sel_data;
            out_src_d  = sel_src;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
`default_nettype wire

// File: doc/forward_select_unit.md
Name: forward_select_unit

Overview:
- Parametrised successor to the fixed 3-way operand-forwarding mux in the MIPS pipeline. Selects one ID-stage source operand from N in-flight producer stages, the writeback port, a short history of retired writes, or the register file.
- Generates a load-use stall.
- Registers the chosen operand into the EX stage. One instance per source operand (rs, rt).

Parameters:
- DATA_WIDTH, 32: operand width.
- REG_ADDR_W, 5: register address width.
- NUM_STAGES, 2: in-flight producer stages; index 0 is nearest to EX and has highest priority.
- HIST_DEPTH, 2: retired-write history entries, ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand request valid from ID
- in_addr  in  REG_ADDR_W  source register number
- in_rf_data  in  DATA_WIDTH  register-file read data
- stage_wen  in  NUM_STAGES  producer i writes a register
- stage_addr  in  NUM_STAGES*REG_ADDR_W  producer destinations; slice i = producer i
- stage_data  in  NUM_STAGES*DATA_WIDTH  producer results
- stage_data_ok  in  NUM_STAGES  producer result available this cycle (0 = load in flight)
- retire_wen  in  1  writeback-stage commit
- retire_addr  in  REG_ADDR_W  commit destination
- retire_data  in  DATA_WIDTH  commit data
- flush  in  1  kill the EX-bound operand
- stall  out  1  combinational; ID must hold in_* this cycle
- out_valid  out  1  registered operand valid
- out_data  out  DATA_WIDTH  registered operand
- out_src  out  SRC_W  registered source code; SRC_W = $clog2(NUM_STAGES+HIST_DEPTH+2)

Behaviour:
- Clock and reset: single clock. rst_n is asynchronous and active-low.
- Reset state: out_valid=0, out_data=0, out_src=0, all history entries invalid. stall is combinational and equals 0 while in_valid=0.
- Match rule: a source matches when it is valid and its address equals in_addr.
- Register 0: in_addr==0 never matches any source. Result is data 0 with src code 0. Writes to address 0 never enter the history.
- Priority among matches, first hit wins:
  - producer 0 .. NUM_STAGES-1
  - retire port
  - history newest .. oldest
  - in_rf_data
- Source codes:
  - 0 = register file
  - 1+i = producer i
  - NUM_STAGES+1 = retire port
  - NUM_STAGES+2+j = history entry j (j=0 newest)
- Stall:
  - Condition: in_valid=1 and the winning match is producer i with stage_data_ok[i]=0.
  - stall=1 in that same cycle.
  - At the next edge: out_valid<=0 (bubble). out_data and out_src hold their previous values.
  - A lower-priority match never hides an unresolved higher-priority producer.
- Latency: 1 cycle. When in_valid=1, stall=0 and flush=0, the next edge loads out_data/out_src with the selection and sets out_valid<=1. When in_valid=0, out_valid<=0.
- Flush: flush=1 forces out_valid<=0 at the next edge, overriding in_valid. The history is unaffected because entries hold committed state.
- History update: on each edge with retire_wen=1 and retire_addr!=0:
  - entry 0 <= {1, retire_addr, retire_data}
  - entry j <= entry j-1
  - the oldest entry is discarded
  - Duplicate addresses are allowed; priority resolves to the newest.
- Same-cycle retire and lookup: the lookup uses the pre-shift history plus the live retire port, so the retire port wins over older history.
- Reset mid-operation: takes effect immediately; no partial shift is retained.
- Arithmetic: none. The only comparators are address equality, REG_ADDR_W bits wide. No width truncation.

Decomposition:
- Package fwd_pkg holds:
  - source-code constants: SRC_RF=0, SRC_STAGE_BASE=1
  - function src_retire(NUM_STAGES)
  - function src_hist(NUM_STAGES, j)
  - function computing SRC_W
  - a packed typedef fwd_entry_t {valid, addr, data} parametrised by the widths
- Sub-module forward_hist_buf: HIST_DEPTH shift register of fwd_entry_t with async active-low reset, flattened entry outputs.

Test Plan:
1. Reset with in_valid=1: assert rst_n=0 mid-cycle -> out_valid=0, out_data=0 and all history invalid immediately; after release, in_addr=5 with no writers -> out_data=in_rf_data, out_src=0 one cycle later.
2. Priority: producer0 writes r3=0x11, producer1 r3=0x22, retire r3=0x33; in_addr=3 -> out_data=0x11, src=1. Drop producer0 -> 0x22, src=2. Drop producer1 -> 0x33, src=3.
3. Load-use: producer0 r7, stage_data_ok[0]=0, producer1 r7=0xAA ok; in_addr=7 -> stall=1 and next out_valid=0. Set data_ok=1 with data 0xBB -> stall=0, out_data=0xBB.
4. History aging (HIST_DEPTH=2): retire r4=0x44, r4=0x55, r6=0x66 on successive cycles, then query r4 -> 0x55, src=NUM_STAGES+3. Retire one more r8 -> r4 falls back to the register file, src=0.
5. Register zero: producer0 writes r0=0xFF and retire writes r0; in_addr=0 -> out_data=0, src=0, history unchanged.
6. Flush: flush=1 with in_valid=1 and a stage hit -> out_valid=0 next cycle; history contents intact on the following query.
